pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Receive-side counterpart of the team's PWM generator (clk, duty_cycle, period, pwm_out).
- Samples an asynchronous PWM input and measures its period and high time in clk cycles.
- Publishes each completed measurement with a one-cycle valid strobe.
- Sits in the FPGA fabric; results are read by firmware on the SmartFusion MSS or looped back to check pwm_out.

Parameters:
- CNT_W, 16: width of the period/duty counters and outputs.
- SYNC_STAGES, 2: flops in the input synchroniser, minimum 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pwm_in  input  1  asynchronous PWM signal under measurement.
- enable  input  1  1 = measure; 0 = return to IDLE, outputs hold.
- period_out  output  CNT_W  cycles between consecutive rising edges.
- duty_out  output  CNT_W  cycles pwm_in was high within that period.
- meas_valid  output  1  one-cycle strobe when period_out/duty_out update.
- timeout  output  1  one-cycle strobe when no edge is seen for 2^CNT_W-1 cycles.
- level  output  1  synchronised pwm_in level, qualifies timeout (stuck high/low).

Behaviour:
- Reset: period_out=0, duty_out=0, meas_valid=0, timeout=0, level=0, sync chain=0, counter=0, state=IDLE.
- Synchroniser: pwm_in passes through SYNC_STAGES flops, then one more flop (prev) for edge detect.
  - rise = sync & ~prev; fall = ~sync & prev.
  - level = sync.
- Counter cnt (CNT_W bits): on rise, cnt loads 1; otherwise it increments while in HIGH or LOW.
- Counter semantics:
  - A value latched on an edge equals the number of synchronised cycles since the previous rise.
  - Example: pwm high 3 cycles, low 5 cycles gives period=8, duty=3.
- States:
  - IDLE: wait for rise (a mid-period start is discarded); on rise go HIGH.
  - HIGH: on fall, capture high_cnt<=cnt, go LOW.
  - LOW: on rise, set period_out<=cnt, duty_out<=high_cnt, pulse meas_valid, then cnt<=1 and go HIGH.
- Latency: meas_valid is asserted SYNC_STAGES+1 clk cycles after the pwm_in rising edge that closes the period. Outputs are stable from that cycle until the next update.
- Saturation and timeout:
  - If cnt reaches 2^CNT_W-1 in HIGH or LOW, pulse timeout for one cycle and go IDLE.
  - period_out/duty_out are untouched; level tells firmware whether the line is stuck high or stuck low.
  - No further timeout pulses occur until a new rise is seen.
- Rise and saturation in the same cycle: the rise wins; a normal measurement is produced with period=2^CNT_W-1.
- Glitch shorter than one clk cycle after synchronisation: counted as a real edge; no filtering in this block.
- Minimum measurable pulse is 1 cycle high / 1 cycle low, giving period=2, duty=1.
- enable=0: state forced to IDLE, cnt=0, no strobes; outputs keep their last values. On re-enable, the first complete period after the first rise is reported.
- rst_n asserted mid-measurement: everything clears immediately (async). Deassertion is synchronised externally, so no partial result is ever emitted.
- meas_valid and timeout are never asserted in the same cycle.

Decomposition:
- Shared package (pwm_pkg): state encoding localparams (IDLE, HIGH, LOW) and the default CNT_W.
  - The generator and capture blocks share CNT_W so widths match in loopback.
- One natural sub-module: sync_edge_det.
  - Parameter SYNC_STAGES; ports clk, rst_n, d_in; outputs level, rise, fall.
  - Reusable for other async inputs such as the CC3000 IRQ line.
- FSM, counter and output registers stay in pwm_capture.

Test Plan:
- Reset: hold rst_n=0 with pwm_in toggling -> all outputs 0, no strobes. Release, then apply 3-high/5-low -> first meas_valid after the second rise with period_out=8, duty_out=3; it repeats every 8 cycles.
- Extremes: 1-high/1-low -> period=2, duty=1 on every rise. Then 100-high/0-low (constant high) -> no meas_valid, and timeout with level=1 after 65535 cycles (CNT_W=16).
- Stuck low: after a valid 10/10 train, hold pwm_in=0 -> period_out stays 20, duty_out stays 10, and one timeout pulse with level=0 occurs 65535 cycles after the last rise, then none.
- Mid-stream start and enable: raise enable while pwm_in is high mid-period -> no measurement until after the first full period. Drop enable mid-period -> no strobe, outputs hold.
- Async reset mid-measurement: assert rst_n=0 while in HIGH with cnt=40 -> outputs clear in the same cycle. After release, the next report matches the stimulus (e.g. 7/9 gives period=16, duty=7).
- Loopback: drive from the PWM generator with period=1000, duty_cycle=250 -> every meas_valid shows period_out=1000, duty_out=250. Change the generator to 400/399 -> the first report after the change is a complete 400/399 period.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg
// Definitions shared by the PWM generator and the PWM capture block.
//   PWM_CNT_W : default width of the period/duty counters. The generator and
//               the capture block both use it, so their widths match when
//               pwm_out is looped back into pwm_in.
//   state_t   : capture FSM encoding (IDLE, HIGH, LOW).
package pwm_pkg;

  localparam int PWM_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det
// Brings an asynchronous single-bit input into the clk domain and reports
// its edges. It is meant for any async input, not just PWM (IRQ lines etc).
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, clears the whole chain
//   d_in  : asynchronous input
//   level : synchronised level of d_in
//   rise  : one-cycle pulse, level went 0 -> 1
//   fall  : one-cycle pulse, level went 1 -> 0
// SYNC_STAGES must be at least 2.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_chain <= '0;
      prev       <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], d_in};
      prev       <= sync_chain[SYNC_STAGES-1];
    end
  end

  // Edges compare the last synchroniser flop with one extra delayed copy.
  assign level = sync_chain[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture
// Measures period and high time of an asynchronous PWM input in clk cycles.
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   pwm_in     : asynchronous PWM signal under measurement
//   enable     : 1 = measure, 0 = park in IDLE (results hold)
//   period_out : cycles between the last two rising edges
//   duty_out   : cycles pwm_in was high within that period
//   meas_valid : one-cycle strobe when period_out/duty_out update
//   timeout    : one-cycle strobe when no edge arrives for 2^CNT_W-1 cycles
//   level      : synchronised pwm_in, tells a timeout stuck-high from stuck-low
// meas_valid rises SYNC_STAGES+1 cycles after the pwm_in edge that closes a
// period.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = PWM_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  input  logic             enable,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] duty_out,
  output logic             meas_valid,
  output logic             timeout,
  output logic             level
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_cnt;
  logic             rise;
  logic             fall;
  logic             saturated;
  logic             do_meas;
  logic             do_high;
  logic             do_timeout;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_in (pwm_in),
    .level(level),
    .rise (rise),
    .fall (fall)
  );

  assign saturated = (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A rise closing a period beats saturation in LOW, so a period of exactly
  // 2^CNT_W-1 is still reported. In HIGH saturation beats a fall.
  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (rise) state_next = HIGH;
        HIGH: begin
          if (saturated)  state_next = IDLE;
          else if (fall)  state_next = LOW;
        end
        LOW: begin
          if (rise)           state_next = HIGH;
          else if (saturated) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    do_meas    = 1'b0;
    do_high    = 1'b0;
    do_timeout = 1'b0;
    if (enable) begin
      case (state)
        HIGH: begin
          do_timeout = saturated;
          do_high    = fall & ~saturated;
        end
        LOW: begin
          do_meas    = rise;
          do_timeout = saturated & ~rise;
        end
        default: ;
      endcase
    end
  end

  // cnt counts synchronised cycles since the last rise; it rests at 0 in IDLE
  // so no stale count can leak into a later measurement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable || do_timeout) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= CNT_ONE;
    end else if (state != IDLE) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_cnt   <= '0;
      period_out <= '0;
      duty_out   <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= do_meas;
      timeout    <= do_timeout;
      if (do_high) high_cnt <= cnt;
      if (do_meas) begin
        period_out <= cnt;
        duty_out   <= high_cnt;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture
// Directed stimulus for pwm_capture with a scoreboard: each stimulus step
// pushes the strobe it should cause (kind, cycle, values) into a queue, and
// a monitor on the falling clock edge pops and compares on every strobe.
// The DUT runs with CNT_W=12 so saturation happens after 4095 cycles.
module tb_pwm_capture;

  localparam int CNT_W = 12;
  localparam int SYNC  = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;
  localparam int LAT   = SYNC + 1;

  typedef struct {
    bit is_to;
    int cyc;
    int per;
    int duty;
    bit lvl;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pwm_in = 1'b0;
  logic             enable = 1'b1;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] duty_out;
  logic             meas_valid;
  logic             timeout;
  logic             level;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  bit   armed = 0;
  int   prev_h = 0;
  int   prev_l = 0;

  pwm_capture #(
    .CNT_W(CNT_W),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_in    (pwm_in),
    .enable    (enable),
    .period_out(period_out),
    .duty_out  (duty_out),
    .meas_valid(meas_valid),
    .timeout   (timeout),
    .level     (level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic void push(bit to, int c, int p, int d, bit lv);
    exp_t e;
    e.is_to = to;
    e.cyc   = c;
    e.per   = p;
    e.duty  = d;
    e.lvl   = lv;
    q.push_back(e);
  endfunction

  // Monitor: every strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (meas_valid || timeout) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe at cycle %0d: meas_valid=%0b timeout=%0b, expected none",
                 cyc, meas_valid, timeout);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("strobe_both", int'(meas_valid && timeout), 0);
        check("strobe_kind", int'(timeout), int'(e.is_to));
        check("strobe_cycle", cyc, e.cyc);
        if (e.is_to) begin
          check("timeout_level", int'(level), int'(e.lvl));
        end else begin
          check("period_out", int'(period_out), e.per);
          check("duty_out", int'(duty_out), e.duty);
        end
      end
    end
  end

  task automatic wait_cycles(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // n pulses of h high / l low; each rise closes the previous period.
  task automatic train(int h, int l, int n);
    for (int i = 0; i < n; i++) begin
      if (armed) push(1'b0, cyc + LAT, prev_h + prev_l, prev_h, 1'b0);
      pwm_in = 1'b1;
      wait_cycles(h);
      pwm_in = 1'b0;
      wait_cycles(l);
      prev_h = h;
      prev_l = l;
      armed  = 1;
    end
  endtask

  // Final rise, then the line sticks high or (after h cycles) sticks low.
  task automatic tail(int h, bit stuck_high, int hold);
    if (armed) push(1'b0, cyc + LAT, prev_h + prev_l, prev_h, 1'b0);
    push(1'b1, cyc + LAT + MAXC, 0, 0, stuck_high);
    pwm_in = 1'b1;
    if (!stuck_high) begin
      wait_cycles(h);
      pwm_in = 1'b0;
    end
    wait_cycles(hold);
    armed = 0;
  endtask

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
    $fatal(1);
  end

  initial begin
    // Reset held while pwm_in toggles: everything stays 0.
    for (int i = 0; i < 6; i++) begin
      pwm_in = ~pwm_in;
      @(negedge clk);
      check("rst_period", int'(period_out), 0);
      check("rst_duty", int'(duty_out), 0);
      check("rst_strobes", int'({meas_valid, timeout}), 0);
      check("rst_level", int'(level), 0);
    end
    @(posedge clk);
    #1;
    pwm_in = 1'b0;
    rst_n  = 1'b1;
    wait_cycles(4);

    // 3 high / 5 low: first report after the second rise.
    armed = 0;
    train(3, 5, 5);
    // Minimum pulse 1/1.
    train(1, 1, 6);
    // Stuck high: timeout with level=1, results hold.
    tail(0, 1'b1, MAXC + 40);
    check("hold_period_hi", int'(period_out), 2);
    check("hold_duty_hi", int'(duty_out), 1);
    pwm_in = 1'b0;
    wait_cycles(20);

    // 10/10 train then stuck low: one timeout with level=0, then none.
    train(10, 10, 4);
    tail(10, 1'b0, 2 * MAXC);
    check("hold_period_lo", int'(period_out), 20);
    check("hold_duty_lo", int'(duty_out), 10);

    // Drop enable mid-period, then re-enable while pwm_in is high.
    train(10, 10, 3);
    push(1'b0, cyc + LAT, 20, 10, 1'b0);
    pwm_in = 1'b1;
    wait_cycles(5);
    enable = 1'b0;
    wait_cycles(5);
    pwm_in = 1'b0;
    wait_cycles(10);
    for (int i = 0; i < 3; i++) begin
      pwm_in = 1'b1;
      wait_cycles(6);
      pwm_in = 1'b0;
      wait_cycles(6);
    end
    check("dis_period", int'(period_out), 20);
    check("dis_duty", int'(duty_out), 10);
    pwm_in = 1'b1;
    wait_cycles(4);
    enable = 1'b1;
    wait_cycles(6);
    pwm_in = 1'b0;
    wait_cycles(10);
    armed = 0;
    train(6, 4, 3);

    // Period of exactly 2^CNT_W-1: the rise wins over saturation.
    train(100, MAXC - 100, 2);
    train(5, 5, 2);

    // Async reset while HIGH with cnt=40.
    check("pre_rst_period", int'(period_out), 10);
    push(1'b0, cyc + LAT, 10, 5, 1'b0);
    pwm_in = 1'b1;
    wait_cycles(LAT + 39);
    rst_n = 1'b0;
    #1;
    check("arst_period", int'(period_out), 0);
    check("arst_duty", int'(duty_out), 0);
    check("arst_level", int'(level), 0);
    check("arst_strobes", int'({meas_valid, timeout}), 0);
    wait_cycles(3);
    pwm_in = 1'b0;
    wait_cycles(1);
    rst_n = 1'b1;
    wait_cycles(4);
    armed = 0;
    train(7, 9, 3);

    // Generator-style loopback: 1000/250, then switch to 400/399.
    train(250, 750, 3);
    train(399, 1, 3);
    train(10, 10, 1);
    wait_cycles(20);

    check("pending_strobes", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
